// File: rtl/fetch_pc_controller_pkg.sv
// Shared fetch-stage definitions: state encoding, pending-kind encoding and default vectors.
package fetch_pc_controller_pkg;

    localparam int          INSTR_BYTES          = 4;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_PEND  = 2'd2,
        ST_HOLD  = 2'd3
    } fetch_state_e;

    // Kind of control transfer parked while a fetch is still outstanding.
    typedef enum logic [1:0] {
        PK_NONE  = 2'd0,
        PK_REDIR = 2'd1,
        PK_TRAP  = 2'd2
    } pend_kind_e;

    // A redirect target that is not word aligned cannot be fetched.
    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return low_bits != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_pc_controller_pc_pending_slot.sv
// Holds one control transfer that arrived while imem had not yet accepted the
// current request. A trap may replace a parked redirect; a redirect never
// replaces anything (it would be on the wrong path).
module pc_pending_slot
    import fetch_pc_controller_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            capture_i,
    input  pend_kind_e      kind_i,
    input  logic [XLEN-1:0] target_i,
    input  logic            clear_i,
    output pend_kind_e      kind_o,
    output logic [XLEN-1:0] target_o
);

    pend_kind_e      kind_q, kind_d;
    logic [XLEN-1:0] target_q, target_d;

    // Clear has priority; a capture is accepted into an empty slot, or when it is a trap.
    always_comb begin
        kind_d   = kind_q;
        target_d = target_q;
        if (clear_i) begin
            kind_d = PK_NONE;
        end else if (capture_i && (kind_i == PK_TRAP || kind_q == PK_NONE)) begin
            kind_d   = kind_i;
            target_d = target_i;
        end
    end

    // Slot registers; reset empties the slot so nothing parked survives a reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            kind_q   <= PK_NONE;
            target_q <= '0;
        end else begin
            kind_q   <= kind_d;
            target_q <= target_d;
        end
    end

    assign kind_o   = kind_q;
    assign target_o = target_q;

endmodule

// File: rtl/fetch_pc_controller.sv
// IF-stage PC sequencer. Drives next_pc/pc_en of the external PC register and
// runs the imem valid/ready fetch handshake.
// Handshake: imem_req is the valid for address pc. Once raised it stays high and
// pc stays unchanged until a cycle where imem_ready=1; that cycle completes the
// transfer, and only then may pc_en load a new PC.
module fetch_pc_controller
    import fetch_pc_controller_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR,
    parameter int              BOOT_DELAY   = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] next_pc,
    output logic            pc_en,
    output logic            imem_req,
    input  logic            imem_ready,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_valid,
    output logic            flush_if,
    output logic            misalign_err,
    output fetch_state_e    dbg_state
);

    localparam int CNT_W = (BOOT_DELAY < 2) ? 1 : $clog2(BOOT_DELAY + 1);

    fetch_state_e    state_q, state_d;
    logic [CNT_W-1:0] boot_cnt_q, boot_cnt_d;

    logic            slot_capture;
    pend_kind_e      slot_cap_kind;
    logic            slot_clear;
    pend_kind_e      slot_kind;
    logic [XLEN-1:0] slot_target;

    pend_kind_e      load_kind;
    logic [XLEN-1:0] load_target;

    pc_pending_slot #(
        .XLEN (XLEN)
    ) u_slot (
        .clk_i     (clock),
        .rst_ni    (reset),
        .capture_i (slot_capture),
        .kind_i    (slot_cap_kind),
        .target_i  (redirect_target),
        .clear_i   (slot_clear),
        .kind_o    (slot_kind),
        .target_o  (slot_target)
    );

    // Next-state and output decode; a chosen control transfer is applied after the case.
    always_comb begin
        state_d       = state_q;
        boot_cnt_d    = boot_cnt_q;
        next_pc       = pc;
        pc_en         = 1'b0;
        imem_req      = 1'b0;
        flush_if      = 1'b0;
        misalign_err  = 1'b0;
        slot_capture  = 1'b0;
        slot_cap_kind = PK_NONE;
        slot_clear    = 1'b0;
        load_kind     = PK_NONE;
        load_target   = redirect_target;

        unique case (state_q)
            ST_BOOT: begin
                next_pc = RESET_VECTOR;
                if (boot_cnt_q != '0) begin
                    boot_cnt_d = boot_cnt_q - CNT_W'(1);
                end
                if (boot_cnt_q <= CNT_W'(1)) begin
                    pc_en   = 1'b1;
                    state_d = ST_FETCH;
                end
            end

            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    if (trap_valid) begin
                        load_kind = PK_TRAP;
                    end else if (redirect_valid) begin
                        load_kind = PK_REDIR;
                    end
                    if (trap_valid || redirect_valid) begin
                        state_d = stall ? ST_HOLD : ST_FETCH;
                    end else if (stall) begin
                        // Fetched word is dropped; the same pc is refetched after the stall.
                        state_d = ST_HOLD;
                    end else begin
                        pc_en   = 1'b1;
                        next_pc = pc + XLEN'(INSTR_BYTES);
                    end
                end else if (trap_valid || redirect_valid) begin
                    slot_capture  = 1'b1;
                    slot_cap_kind = trap_valid ? PK_TRAP : PK_REDIR;
                    state_d       = ST_PEND;
                end
            end

            ST_PEND: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    load_kind   = trap_valid ? PK_TRAP : slot_kind;
                    load_target = slot_target;
                    slot_clear  = 1'b1;
                    state_d     = stall ? ST_HOLD : ST_FETCH;
                end else if (trap_valid) begin
                    slot_capture  = 1'b1;
                    slot_cap_kind = PK_TRAP;
                end
            end

            ST_HOLD: begin
                if (trap_valid) begin
                    load_kind = PK_TRAP;
                end else if (redirect_valid) begin
                    load_kind = PK_REDIR;
                end
                state_d = stall ? ST_HOLD : ST_FETCH;
            end

            default: begin
                state_d = ST_BOOT;
            end
        endcase

        if (load_kind == PK_TRAP) begin
            next_pc  = TRAP_VECTOR;
            pc_en    = 1'b1;
            flush_if = 1'b1;
        end else if (load_kind == PK_REDIR) begin
            pc_en    = 1'b1;
            flush_if = 1'b1;
            if (is_misaligned(load_target[1:0])) begin
                next_pc      = TRAP_VECTOR;
                misalign_err = 1'b1;
            end else begin
                next_pc = load_target;
            end
        end
    end

    // State and boot counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_BOOT;
            boot_cnt_q <= CNT_W'(BOOT_DELAY);
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
        end
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_fetch_pc_controller.sv
module tb_fetch_pc_controller;
    import fetch_pc_controller_pkg::*;

    logic         clock;
    logic         reset;
    logic [31:0]  pc;
    logic [31:0]  next_pc;
    logic         pc_en;
    logic         imem_req;
    logic         imem_ready;
    logic         stall;
    logic         redirect_valid;
    logic [31:0]  redirect_target;
    logic         trap_valid;
    logic         flush_if;
    logic         misalign_err;
    fetch_state_e dbg_state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        stall;
        logic        ready;
        logic        rv;
        logic [31:0] rt;
        logic        tv;
        logic [31:0] e_pc;
        logic        e_en;
        logic [31:0] e_next;
        logic        e_req;
        logic        e_flush;
        logic        e_mis;
    } vec_t;

    localparam int NVEC = 22;
    vec_t vecs [NVEC];

    fetch_pc_controller #(
        .XLEN         (32),
        .RESET_VECTOR (32'h0000_0000),
        .TRAP_VECTOR  (32'h0000_0100),
        .BOOT_DELAY   (2)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .pc              (pc),
        .next_pc         (next_pc),
        .pc_en           (pc_en),
        .imem_req        (imem_req),
        .imem_ready      (imem_ready),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .trap_valid      (trap_valid),
        .flush_if        (flush_if),
        .misalign_err    (misalign_err),
        .dbg_state       (dbg_state)
    );

    // Clock and the external PC register the controller steers.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) pc <= 32'h0000_0000;
        else if (pc_en) pc <= next_pc;
    end

    function automatic vec_t mk(input logic st, input logic rdy, input logic rv,
                                input logic [31:0] rt, input logic tv,
                                input logic [31:0] e_pc, input logic e_en,
                                input logic [31:0] e_next, input logic e_req,
                                input logic e_flush, input logic e_mis);
        vec_t v;
        v.stall = st; v.ready = rdy; v.rv = rv; v.rt = rt; v.tv = tv;
        v.e_pc = e_pc; v.e_en = e_en; v.e_next = e_next;
        v.e_req = e_req; v.e_flush = e_flush; v.e_mis = e_mis;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Drive inputs on the falling edge and let them settle before sampling.
    task automatic cyc(input logic st, input logic rdy, input logic rv,
                       input logic [31:0] rt, input logic tv);
        @(negedge clock);
        stall = st; imem_ready = rdy; redirect_valid = rv;
        redirect_target = rt; trap_valid = tv;
        #2;
    endtask

    task automatic chk_outs(input string tag, input logic [31:0] e_pc, input logic e_en,
                            input logic [31:0] e_next, input logic e_req,
                            input logic e_flush, input logic e_mis);
        chk({tag, ".pc"}, pc, e_pc);
        chk({tag, ".pc_en"}, 32'(pc_en), 32'(e_en));
        if (e_en) chk({tag, ".next_pc"}, next_pc, e_next);
        chk({tag, ".imem_req"}, 32'(imem_req), 32'(e_req));
        chk({tag, ".flush_if"}, 32'(flush_if), 32'(e_flush));
        chk({tag, ".misalign_err"}, 32'(misalign_err), 32'(e_mis));
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, ".pc_en"}, 32'(pc_en), 32'd0);
        chk({tag, ".imem_req"}, 32'(imem_req), 32'd0);
        chk({tag, ".flush_if"}, 32'(flush_if), 32'd0);
        chk({tag, ".misalign_err"}, 32'(misalign_err), 32'd0);
        chk({tag, ".next_pc"}, next_pc, 32'h0000_0000);
        chk({tag, ".state"}, 32'(dbg_state), 32'(ST_BOOT));
    endtask

    initial begin
        //              st rdy rv target        tv  exp_pc        en  exp_next      req fl  mis
        vecs[0]  = mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 0, 0);
        vecs[1]  = mk(0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h0,        0, 0, 0);
        vecs[2]  = mk(0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h4,        1, 0, 0);
        vecs[3]  = mk(0, 1, 0, 32'h0,        0, 32'h4,        1, 32'h8,        1, 0, 0);
        vecs[4]  = mk(1, 1, 0, 32'h0,        0, 32'h8,        0, 32'h0,        1, 0, 0);
        vecs[5]  = mk(1, 0, 0, 32'h0,        0, 32'h8,        0, 32'h0,        0, 0, 0);
        vecs[6]  = mk(0, 0, 0, 32'h0,        0, 32'h8,        0, 32'h0,        0, 0, 0);
        vecs[7]  = mk(0, 1, 0, 32'h0,        0, 32'h8,        1, 32'hC,        1, 0, 0);
        vecs[8]  = mk(0, 1, 0, 32'h0,        0, 32'hC,        1, 32'h10,       1, 0, 0);
        vecs[9]  = mk(0, 1, 1, 32'h80,       1, 32'h10,       1, 32'h100,      1, 1, 0);
        vecs[10] = mk(0, 1, 0, 32'h0,        0, 32'h100,      1, 32'h104,      1, 0, 0);
        vecs[11] = mk(0, 1, 1, 32'h42,       0, 32'h104,      1, 32'h100,      1, 1, 1);
        vecs[12] = mk(0, 1, 0, 32'h0,        0, 32'h100,      1, 32'h104,      1, 0, 0);
        vecs[13] = mk(0, 1, 1, 32'h200,      0, 32'h104,      1, 32'h200,      1, 1, 0);
        vecs[14] = mk(1, 1, 1, 32'h300,      0, 32'h200,      1, 32'h300,      1, 1, 0);
        vecs[15] = mk(1, 0, 0, 32'h0,        1, 32'h300,      1, 32'h100,      0, 1, 0);
        vecs[16] = mk(0, 0, 0, 32'h0,        0, 32'h100,      0, 32'h0,        0, 0, 0);
        vecs[17] = mk(0, 1, 0, 32'h0,        0, 32'h100,      1, 32'h104,      1, 0, 0);
        vecs[18] = mk(0, 1, 1, 32'hFFFF_FFFC, 0, 32'h104,     1, 32'hFFFF_FFFC, 1, 1, 0);
        vecs[19] = mk(0, 1, 0, 32'h0,        0, 32'hFFFF_FFFC, 1, 32'h0,       1, 0, 0);
        vecs[20] = mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 0, 0);
        vecs[21] = mk(0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h4,        1, 0, 0);

        // Reset state.
        reset = 1'b0; stall = 1'b0; imem_ready = 1'b1; redirect_valid = 1'b0;
        redirect_target = 32'h0; trap_valid = 1'b0;
        repeat (2) @(negedge clock);
        #2;
        chk_reset_outs("reset");
        @(posedge clock);
        #1 reset = 1'b1;

        // Boot, sequential fetch, stall, priority, misalign, wrap.
        for (int i = 0; i < NVEC; i++) begin
            cyc(vecs[i].stall, vecs[i].ready, vecs[i].rv, vecs[i].rt, vecs[i].tv);
            chk_outs($sformatf("v%0d", i), vecs[i].e_pc, vecs[i].e_en, vecs[i].e_next,
                     vecs[i].e_req, vecs[i].e_flush, vecs[i].e_mis);
        end

        // Slow imem with a parked redirect; a later redirect is ignored.
        cyc(0, 0, 1, 32'h40, 0); chk_outs("slow.c1", 32'h4, 0, 32'h0, 1, 0, 0);
        chk("slow.c1.state", 32'(dbg_state), 32'(ST_FETCH));
        cyc(0, 0, 1, 32'h80, 0); chk_outs("slow.c2", 32'h4, 0, 32'h0, 1, 0, 0);
        chk("slow.c2.state", 32'(dbg_state), 32'(ST_PEND));
        cyc(0, 0, 0, 32'h0, 0);  chk_outs("slow.c3", 32'h4, 0, 32'h0, 1, 0, 0);
        cyc(0, 1, 0, 32'h0, 0);  chk_outs("slow.rdy", 32'h4, 1, 32'h40, 1, 1, 0);
        cyc(0, 1, 0, 32'h0, 0);  chk_outs("slow.after", 32'h40, 1, 32'h44, 1, 0, 0);

        // A trap arriving while a redirect is parked replaces it.
        cyc(0, 0, 1, 32'h60, 0); chk_outs("ovr.c1", 32'h44, 0, 32'h0, 1, 0, 0);
        cyc(0, 0, 0, 32'h0, 1);  chk_outs("ovr.c2", 32'h44, 0, 32'h0, 1, 0, 0);
        cyc(0, 1, 0, 32'h0, 0);  chk_outs("ovr.rdy", 32'h44, 1, 32'h100, 1, 1, 0);

        // Reset while a redirect is parked.
        cyc(0, 0, 1, 32'h80, 0); chk_outs("rst.pend", 32'h100, 0, 32'h0, 1, 0, 0);
        @(negedge clock);
        redirect_valid = 1'b1; redirect_target = 32'h80; imem_ready = 1'b1; reset = 1'b0;
        #1;
        chk_reset_outs("rst.mid");
        @(negedge clock);
        #2;
        chk_reset_outs("rst.hold");
        @(posedge clock);
        #1 reset = 1'b1;
        cyc(0, 1, 1, 32'h80, 1); chk_outs("rst.boot1", 32'h0, 0, 32'h0, 0, 0, 0);
        cyc(0, 1, 1, 32'h80, 1); chk_outs("rst.boot2", 32'h0, 1, 32'h0, 0, 0, 0);
        cyc(0, 1, 0, 32'h0, 0);  chk_outs("rst.first", 32'h0, 1, 32'h4, 1, 0, 0);
        cyc(0, 1, 0, 32'h0, 0);  chk_outs("rst.second", 32'h4, 1, 32'h8, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
